// File: rtl/feature_linebuffer_pkg.sv
// Shared logistic-regression constants.
// Used by the feature line buffer, the inner-product stage and the theta stage
// so that all three agree on vector length, sample width and index width.
package feature_linebuffer_pkg;

  localparam int NFEAT = 41;               // feature-vector length
  localparam int W     = 32;               // sample / feature width
  localparam int CNT_W = $clog2(NFEAT);    // feature index width

endpackage

// File: rtl/feature_slot_bank.sv
// Assembly storage for a partially received feature vector.
// Holds features 0..NSLOT-1; the final feature of a vector never lands here,
// it goes straight into the output register of the line buffer.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears all slots)
//   wr_en        write wr_data into slot wr_idx this cycle
//   wr_idx       slot index, must be < NSLOT when wr_en is set
//   wr_data      sample to store
//   slots        current slot contents
module feature_slot_bank
  import feature_linebuffer_pkg::*;
#(
  parameter int NSLOT = feature_linebuffer_pkg::NFEAT - 1,
  parameter int DW    = feature_linebuffer_pkg::W,
  parameter int IDX_W = feature_linebuffer_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  output logic [DW-1:0]    slots [0:NSLOT-1]
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLOT; k++) slots[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (wr_idx == IDX_W'(k)) slots[k] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/feature_linebuffer.sv
// Serial-to-parallel feature line buffer.
// Collects NFEAT serial samples into a vector and presents it, registered,
// to the inner-product stage with a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/in_valid      serial sample input
//   in_sof                marks the sample as feature index 0
//   in_ready              sample accepted this cycle when in_valid is high
//   xarray                assembled feature vector
//   out_valid/out_ready   output handshake
//   sof_err               one-cycle pulse: vector restarted before completion
module feature_linebuffer
  import feature_linebuffer_pkg::*;
#(
  parameter int NFEAT = feature_linebuffer_pkg::NFEAT,
  parameter int W     = feature_linebuffer_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sof,
  output logic         in_ready,
  output logic [W-1:0] xarray [0:NFEAT-1],
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sof_err
);

  localparam int CW = $clog2(NFEAT);

  logic [CW-1:0] cnt;
  logic          at_last;
  logic          accept;
  logic          last_smp;
  logic [W-1:0]  slots [0:NFEAT-2];

  assign at_last  = (cnt == CW'(NFEAT - 1));
  // Only the final sample can stall: it needs the output register to be free
  // (or being drained this same cycle).
  assign in_ready = rst_n && !(at_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  // A start-of-frame always wins over completing the current vector.
  assign last_smp = accept && !in_sof && at_last;

  feature_slot_bank #(
    .NSLOT (NFEAT - 1),
    .DW    (W),
    .IDX_W (CW)
  ) u_slot_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && !last_smp),
    .wr_idx  (in_sof ? '0 : cnt),
    .wr_data (in_data),
    .slots   (slots)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      sof_err   <= 1'b0;
      for (int k = 0; k < NFEAT; k++) xarray[k] <= '0;
    end else begin
      sof_err <= accept && in_sof && (cnt != '0);

      if (accept) begin
        if (in_sof)        cnt <= CW'(1);
        else if (at_last)  cnt <= '0;
        else               cnt <= cnt + 1'b1;
      end

      if (last_smp) begin
        for (int k = 0; k < NFEAT - 1; k++) xarray[k] <= slots[k];
        xarray[NFEAT-1] <= in_data;
        out_valid       <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_feature_linebuffer.sv
// Self-checking bench for feature_linebuffer: directed scenarios plus a random
// phase, all checked cycle by cycle against a queue-based reference model.
module tb_feature_linebuffer;
  import feature_linebuffer_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic [W-1:0] xarray [0:NFEAT-1];
  logic         out_valid;
  logic         out_ready;
  logic         sof_err;

  feature_linebuffer #(.NFEAT(NFEAT), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .xarray    (xarray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sof_err   (sof_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_xfer = 0;

  // reference model: samples of the vector in progress, output register image
  logic [W-1:0] cur [$];
  logic [W-1:0] m_x [NFEAT];
  logic         m_ov  = 1'b0;
  logic         m_err = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs at negedge, update the model at the edge,
  // return whether the model says the presented sample was accepted.
  task automatic cycle(output logic acc);
    logic exp_rdy;
    logic done;
    @(negedge clk);
    exp_rdy = rst_n && !(cur.size() == NFEAT - 1 && m_ov && !out_ready);
    chk("in_ready",  W'(in_ready),  W'(exp_rdy));
    chk("out_valid", W'(out_valid), W'(m_ov));
    chk("sof_err",   W'(sof_err),   W'(m_err));
    for (int k = 0; k < NFEAT; k++) begin
      if (xarray[k] !== m_x[k]) chk($sformatf("xarray[%0d]", k), xarray[k], m_x[k]);
      else chk("xarray", xarray[k], m_x[k]);
    end
    acc = in_valid && exp_rdy;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      cur.delete();
      m_ov  = 1'b0;
      m_err = 1'b0;
      for (int k = 0; k < NFEAT; k++) m_x[k] = '0;
    end else begin
      if (m_ov && out_ready) n_xfer++;
      m_err = acc && in_sof && (cur.size() != 0);
      done  = 1'b0;
      if (acc) begin
        if (in_sof) cur.delete();
        cur.push_back(in_data);
        if (cur.size() == NFEAT) begin
          for (int k = 0; k < NFEAT; k++) m_x[k] = cur[k];
          cur.delete();
          done = 1'b1;
        end
      end
      if (done) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));   // must be ignored while idle
      in_data  = $urandom;
      cycle(a);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic sof);
    logic a;
    int   n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    do begin
      cycle(a);
      n++;
    end while (!a && n < 100);
    if (!a) chk("send_timeout", W'(0), W'(1));
  endtask

  task automatic send_vec(input logic [W-1:0] v [NFEAT], input int gap_pct, input logic sof_first);
    for (int i = 0; i < NFEAT; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      send(v[i], sof_first && i == 0);
    end
  endtask

  logic [W-1:0] va [NFEAT];
  logic [W-1:0] vb [NFEAT];
  logic [W-1:0] cap [NFEAT];
  logic         a;
  int           c0, x0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < NFEAT; k++) m_x[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(a);                // in_ready must be low during reset
    rst_n = 1'b1;
    idle(2);

    // 1: basic vector, values k+1
    for (int k = 0; k < NFEAT; k++) va[k] = W'(k + 1);
    send_vec(va, 0, 1'b1);
    in_valid = 1'b0;
    chk("s1_ov", W'(out_valid), W'(1));
    for (int k = 0; k < NFEAT; k++) chk("s1_x", xarray[k], W'(k + 1));
    idle(2);

    // 2: out_ready held low, two vectors, last sample of vector 2 stalls
    out_ready = 1'b0;
    for (int k = 0; k < NFEAT; k++) begin va[k] = $urandom; vb[k] = $urandom; end
    send_vec(va, 0, 1'b1);
    for (int i = 0; i < NFEAT - 1; i++) send(vb[i], i == 0);
    in_valid = 1'b1; in_sof = 1'b0; in_data = vb[NFEAT-1];
    repeat (3) begin
      cycle(a);
      chk("s2_stall", W'(a), W'(0));
    end
    for (int k = 0; k < NFEAT; k++) chk("s2_hold", xarray[k], va[k]);
    out_ready = 1'b1;
    cycle(a);
    chk("s2_release", W'(a), W'(1));
    chk("s2_ov", W'(out_valid), W'(1));
    for (int k = 0; k < NFEAT; k++) chk("s2_vb", xarray[k], vb[k]);
    idle(2);

    // 3: restart after 20 samples
    x0 = n_xfer;
    for (int i = 0; i < 20; i++) send($urandom, i == 0);
    send(32'hAAAA_0000, 1'b1);
    chk("s3_err", W'(sof_err), W'(1));
    for (int i = 1; i < NFEAT; i++) send($urandom, 1'b0);
    in_valid = 1'b0;
    chk("s3_x0", xarray[0], 32'hAAAA_0000);
    chk("s3_noxfer", W'(n_xfer - x0), W'(0));
    idle(2);
    chk("s3_xfer", W'(n_xfer - x0), W'(1));

    // 4: back-to-back vectors, continuous valid
    c0 = cyc; x0 = n_xfer;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < NFEAT; k++) va[k] = $urandom;
      send_vec(va, 0, 1'b1);
    end
    chk("s4_cycles", W'(cyc - c0), W'(3 * NFEAT));
    idle(1);
    chk("s4_xfers", W'(n_xfer - x0), W'(3));

    // 5: reset after 30 samples; next vector starts at slot 0 without sof
    for (int i = 0; i < 30; i++) send($urandom, i == 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle(a);
    rst_n = 1'b1;
    chk("s5_ov", W'(out_valid), W'(0));
    for (int k = 0; k < NFEAT; k++) chk("s5_zero", xarray[k], '0);
    for (int k = 0; k < NFEAT; k++) va[k] = $urandom;
    send_vec(va, 0, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < NFEAT; k++) chk("s5_x", xarray[k], va[k]);
    idle(1);

    // 6: same vector with and without gaps gives identical contents
    for (int k = 0; k < NFEAT; k++) va[k] = $urandom;
    send_vec(va, 0, 1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < NFEAT; k++) cap[k] = xarray[k];
    idle(1);
    send_vec(va, 40, 1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < NFEAT; k++) chk("s6_same", xarray[k], cap[k]);
    idle(1);

    // 7: random traffic, random backpressure, occasional restarts
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sof    = ($urandom_range(0, 40) == 0);
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      cycle(a);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
